// File: rtl/crp16_scoreboard_register_file.sv
// Parametrised register file with a per-register busy scoreboard for multi-cycle producers.
// Optional RF_WRITE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module crp16_scoreboard_register_file #(
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [SEL_W-1:0]  reg_a_select,
  input  logic [SEL_W-1:0]  reg_b_select,
  output logic [DATA_W-1:0] reg_a_val,
  output logic [DATA_W-1:0] reg_b_val,
  output logic              reg_a_ready,
  output logic              reg_b_ready,
  input  logic [DATA_W-1:0] load_val,
  input  logic [SEL_W-1:0]  write_select,
  input  logic              write,
  input  logic              reserve,
  input  logic [SEL_W-1:0]  reserve_select,
  output logic              reserve_ok,
  output logic [SEL_W:0]    busy_count
);
  localparam int NUM_REGS = 2**SEL_W;
  localparam logic [SEL_W:0] CNT_ONE = {{SEL_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [SEL_W:0]      count_q;
  logic                write_en;
  logic                cnt_dec;
  logic [SEL_W-1:0]    rd_sel [2];
  logic [DATA_W-1:0]   rd_val [2];
  logic                rd_rdy [2];

  function automatic logic is_zero_reg(input logic [SEL_W-1:0] sel);
    return (ZERO_REG != 0) && (sel == '0);
  endfunction

  assign write_en   = write & ~is_zero_reg(write_select);
  assign reserve_ok = reserve & ~busy[reserve_select] & ~is_zero_reg(reserve_select);
  // An accepted reserve always targets a clear bit, so inc and dec never cancel on one register.
  assign cnt_dec    = write_en & busy[write_select];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy    <= '0;
      count_q <= '0;
    end else begin
      if (write_en) begin
        regs[write_select] <= load_val;
        busy[write_select] <= 1'b0;
      end
      // Placed after the write clear so a same-cycle reservation of the same register wins.
      if (reserve_ok) busy[reserve_select] <= 1'b1;
      case ({reserve_ok, cnt_dec})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_sel[0] = reg_a_select;
  assign rd_sel[1] = reg_b_select;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = is_zero_reg(rd_sel[p]) ? '0 : regs[rd_sel[p]];
      rd_rdy[p] = ~busy[rd_sel[p]];
`ifdef RF_WRITE_BYPASS_EN
      if (write_en && (rd_sel[p] == write_select)) begin
        rd_val[p] = load_val;
        rd_rdy[p] = ~(reserve_ok && (reserve_select == write_select));
      end
`endif
    end
  end

  assign reg_a_val   = rd_val[0];
  assign reg_b_val   = rd_val[1];
  assign reg_a_ready = rd_rdy[0];
  assign reg_b_ready = rd_rdy[1];
  assign busy_count  = count_q;

endmodule
